// File: rtl/wb_i2c_seq_if.sv
// Request/response and Wishbone signals of the I2C transfer sequencer.
// The master modport is the sequencer; the slave modport is its environment (requester plus I2C core).
interface wb_i2c_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rnw;
  logic [6:0] req_dev;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       rsp_err;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic       wb_ack_i;
  logic       wb_inta_i;

  // Handshake: a request transfers on a clock edge where req_valid && req_ready;
  // rsp_valid is a single-cycle pulse with no backpressure; a Wishbone cycle
  // holds cyc/stb/we/adr/dat stable until the edge that samples wb_ack_i=1.
  modport master (
    input  req_valid, req_rnw, req_dev, req_data, wb_dat_i, wb_ack_i, wb_inta_i,
    output req_ready, rsp_valid, rsp_data, rsp_nack, rsp_err,
           wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output req_valid, req_rnw, req_dev, req_data, wb_dat_i, wb_ack_i, wb_inta_i,
    input  req_ready, rsp_valid, rsp_data, rsp_nack, rsp_err,
           wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/wb_i2c_seq.sv
// Wishbone master that drives an I2C master core through single-byte transfers.
// Optional macro WB_I2C_SEQ_IRQ_EN: wait on wb_inta_i instead of polling SR, with IACK set.
module wb_i2c_seq #(
  parameter logic [15:0] PRESCALE    = 16'h00C7,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          POLL_GAP    = 4
) (
  input  logic             wb_clk_i,
  input  logic             arst_i,
  wb_i2c_seq_if.master     bus,
  output logic [3:0]       dbg_state
);

  localparam logic [3:0] S_INIT_PLO = 4'd0;
  localparam logic [3:0] S_INIT_PHI = 4'd1;
  localparam logic [3:0] S_INIT_CTR = 4'd2;
  localparam logic [3:0] S_IDLE     = 4'd3;
  localparam logic [3:0] S_TX_ADDR  = 4'd4;
  localparam logic [3:0] S_CR_START = 4'd5;
  localparam logic [3:0] S_WAIT     = 4'd6;
  localparam logic [3:0] S_CR_STOP  = 4'd7;
  localparam logic [3:0] S_TX_DATA  = 4'd8;
  localparam logic [3:0] S_CR_WSTO  = 4'd9;
  localparam logic [3:0] S_CR_RSTO  = 4'd10;
  localparam logic [3:0] S_RD_RXR   = 4'd11;
  localparam logic [3:0] S_RESP     = 4'd12;

  localparam logic [1:0] PH_ADDR  = 2'd0;
  localparam logic [1:0] PH_STOP  = 2'd1;
  localparam logic [1:0] PH_WDATA = 2'd2;
  localparam logic [1:0] PH_RDATA = 2'd3;

  localparam logic [2:0] REG_PLO = 3'd0;
  localparam logic [2:0] REG_PHI = 3'd1;
  localparam logic [2:0] REG_CTR = 3'd2;
  localparam logic [2:0] REG_TXR = 3'd3;
  localparam logic [2:0] REG_CR  = 3'd4;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [3:0]    state;
  logic [1:0]    phase;
  logic          cyc_q;
  logic          we_q;
  logic [2:0]    adr_q;
  logic [7:0]    dat_q;
  logic [TW-1:0] ack_cnt;
  logic          rnw_q;
  logic [6:0]    dev_q;
  logic [7:0]    data_q;
  logic [7:0]    pend_data;
  logic          pend_nack;
  logic          pend_err;
  logic          rsp_valid_q;
  logic [7:0]    rsp_data_q;
  logic          rsp_nack_q;
  logic          rsp_err_q;

  logic          acc_go;
  logic          acc_we;
  logic [2:0]    acc_adr;
  logic [7:0]    acc_dat;
  logic          poll_now;
  logic [7:0]    ctr_val;
  logic [7:0]    iack;
  logic          is_cr_write;

  assign is_cr_write = (state == S_CR_START) || (state == S_CR_STOP) ||
                       (state == S_CR_WSTO)  || (state == S_CR_RSTO);

`ifdef WB_I2C_SEQ_IRQ_EN
  localparam int unused_poll_gap = POLL_GAP;
  // The very first CR write after reset has no pending interrupt to acknowledge.
  logic cr_seen;

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i)
      cr_seen <= 1'b0;
    else if (cyc_q && bus.wb_ack_i && is_cr_write)
      cr_seen <= 1'b1;
  end

  assign ctr_val  = 8'hC0;
  assign iack     = {7'd0, cr_seen};
  assign poll_now = bus.wb_inta_i;
`else
  localparam int GW = $clog2(POLL_GAP + 2);
  logic [GW-1:0] gap_cnt;
  logic          unused_inta;

  assign unused_inta = bus.wb_inta_i;

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i)
      gap_cnt <= '0;
    else if (cyc_q && bus.wb_ack_i && (is_cr_write || state == S_WAIT))
      gap_cnt <= GW'(POLL_GAP);
    else if (!cyc_q && state == S_WAIT && gap_cnt != '0)
      gap_cnt <= gap_cnt - 1'b1;
  end

  assign ctr_val  = 8'h80;
  assign iack     = 8'h00;
  assign poll_now = (gap_cnt == '0);
`endif

  // What bus access the current state wants to launch once the bus is idle.
  always_comb begin
    acc_go  = 1'b0;
    acc_we  = 1'b1;
    acc_adr = REG_PLO;
    acc_dat = 8'h00;
    case (state)
      S_INIT_PLO: begin acc_go = 1'b1; acc_adr = REG_PLO; acc_dat = PRESCALE[7:0];  end
      S_INIT_PHI: begin acc_go = 1'b1; acc_adr = REG_PHI; acc_dat = PRESCALE[15:8]; end
      S_INIT_CTR: begin acc_go = 1'b1; acc_adr = REG_CTR; acc_dat = ctr_val;        end
      S_TX_ADDR:  begin acc_go = 1'b1; acc_adr = REG_TXR; acc_dat = {dev_q, rnw_q}; end
      S_CR_START: begin acc_go = 1'b1; acc_adr = REG_CR;  acc_dat = 8'h90 | iack;   end
      S_CR_STOP:  begin acc_go = 1'b1; acc_adr = REG_CR;  acc_dat = 8'h40 | iack;   end
      S_TX_DATA:  begin acc_go = 1'b1; acc_adr = REG_TXR; acc_dat = data_q;         end
      S_CR_WSTO:  begin acc_go = 1'b1; acc_adr = REG_CR;  acc_dat = 8'h50 | iack;   end
      S_CR_RSTO:  begin acc_go = 1'b1; acc_adr = REG_CR;  acc_dat = 8'h68 | iack;   end
      S_WAIT:     begin acc_go = poll_now; acc_we = 1'b0; acc_adr = REG_CR;        end
      S_RD_RXR:   begin acc_go = 1'b1; acc_we = 1'b0; acc_adr = REG_TXR;           end
      default:    ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state       <= S_INIT_PLO;
      phase       <= PH_ADDR;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 3'd0;
      dat_q       <= 8'h00;
      ack_cnt     <= '0;
      rnw_q       <= 1'b0;
      dev_q       <= 7'd0;
      data_q      <= 8'h00;
      pend_data   <= 8'h00;
      pend_nack   <= 1'b0;
      pend_err    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_nack_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (cyc_q) begin
        if (bus.wb_ack_i) begin
          cyc_q   <= 1'b0;
          ack_cnt <= '0;
          case (state)
            S_INIT_PLO: state <= S_INIT_PHI;
            S_INIT_PHI: state <= S_INIT_CTR;
            S_INIT_CTR: state <= S_IDLE;
            S_TX_ADDR:  state <= S_CR_START;
            S_CR_START: begin state <= S_WAIT; phase <= PH_ADDR;  end
            S_CR_STOP:  begin state <= S_WAIT; phase <= PH_STOP;  end
            S_TX_DATA:  state <= S_CR_WSTO;
            S_CR_WSTO:  begin state <= S_WAIT; phase <= PH_WDATA; end
            S_CR_RSTO:  begin state <= S_WAIT; phase <= PH_RDATA; end
            S_RD_RXR:   begin pend_data <= bus.wb_dat_i; state <= S_RESP; end
            S_WAIT: begin
              // SR[1] is TIP, SR[7] is RxACK (1 = slave did not acknowledge).
              if (!bus.wb_dat_i[1]) begin
                case (phase)
                  PH_ADDR: begin
                    if (bus.wb_dat_i[7])
                      state <= S_CR_STOP;
                    else if (rnw_q)
                      state <= S_CR_RSTO;
                    else
                      state <= S_TX_DATA;
                  end
                  PH_STOP:  begin pend_nack <= 1'b1; state <= S_RESP; end
                  PH_WDATA: begin pend_nack <= bus.wb_dat_i[7]; state <= S_RESP; end
                  default:  state <= S_RD_RXR;
                endcase
              end
            end
            default: state <= S_IDLE;
          endcase
        end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
          cyc_q     <= 1'b0;
          ack_cnt   <= '0;
          pend_err  <= 1'b1;
          pend_nack <= 1'b0;
          state     <= S_RESP;
        end else begin
          ack_cnt <= ack_cnt + 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.req_valid) begin
              rnw_q     <= bus.req_rnw;
              dev_q     <= bus.req_dev;
              data_q    <= bus.req_data;
              pend_data <= 8'h00;
              pend_nack <= 1'b0;
              pend_err  <= 1'b0;
              state     <= S_TX_ADDR;
            end
          end
          S_RESP: begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= pend_data;
            rsp_nack_q  <= pend_nack;
            rsp_err_q   <= pend_err;
            state       <= S_IDLE;
          end
          default: ;
        endcase
        if (acc_go) begin
          cyc_q <= 1'b1;
          we_q  <= acc_we;
          adr_q <= acc_adr;
          dat_q <= acc_dat;
        end
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_nack  = rsp_nack_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = dat_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_wb_i2c_seq.sv
// Directed bench for wb_i2c_seq with a small behavioural I2C-core register model.
module tb_wb_i2c_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] dbg_state;

  wb_i2c_seq_if bus();

  wb_i2c_seq dut (
    .wb_clk_i  (clk),
    .arst_i    (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // core model controls
  logic       ack_block;
  logic       sr_rxack;
  logic [7:0] rxr_val;
  logic       ack_q;
  logic [4:0] tip_cnt;

  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];

  int total;
  int passed;

  logic [7:0] r_data;
  logic       r_nack;
  logic       r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      tip_cnt <= 5'd0;
    end else begin
      ack_q <= bus.wb_cyc_o && bus.wb_stb_o && !ack_q && !ack_block;
      if (bus.wb_cyc_o && ack_q && bus.wb_we_o && bus.wb_adr_o == 3'd4)
        tip_cnt <= 5'd12;
      else if (tip_cnt != 5'd0)
        tip_cnt <= tip_cnt - 5'd1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.wb_cyc_o && bus.wb_stb_o && ack_q && bus.wb_we_o)
      obs_q.push_back({bus.wb_adr_o, bus.wb_dat_o});
  end

  assign bus.wb_ack_i  = ack_q;
  assign bus.wb_inta_i = 1'b0;
  assign bus.wb_dat_i  = (bus.wb_adr_o == 3'd3) ? rxr_val :
                         (bus.wb_adr_o == 3'd4) ? {sr_rxack, 5'd0, (tip_cnt != 5'd0), 1'b0} :
                         8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic expect_wr(input logic [2:0] adr, input logic [7:0] dat);
    exp_q.push_back({adr, dat});
  endtask

  // scoreboard: compare recorded core writes against the expected queue
  task automatic sb_drain(input string tag);
    logic [10:0] o;
    logic [10:0] e;
    check({tag, "_wr_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : 11'h7FF;
      check({tag, "_wr"}, o, e);
    end
    obs_q.delete();
  endtask

  task automatic send(input string tag, input logic rnw, input logic [6:0] dev,
                      input logic [7:0] data);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
    end
    check({tag, "_ready_wait"}, ok, 1);
    bus.req_rnw   = rnw;
    bus.req_dev   = dev;
    bus.req_data  = data;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check({tag, "_ready_drop"}, bus.req_ready, 0);
  endtask

  task automatic wait_rsp(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got    = 1'b1;
        r_data = bus.rsp_data;
        r_nack = bus.rsp_nack;
        r_err  = bus.rsp_err;
      end
    end
    check({tag, "_rsp_seen"}, got, 1);
    @(negedge clk);
    check({tag, "_rsp_one_pulse"}, bus.rsp_valid, 0);
  endtask

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
    end
    check(tag, ok, 1);
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    rst_n     = 1'b0;
    ack_block = 1'b0;
    sr_rxack  = 1'b0;
    rxr_val   = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_rnw   = 1'b0;
    bus.req_dev   = 7'd0;
    bus.req_data  = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_fields", {bus.rsp_data, bus.rsp_nack, bus.rsp_err}, 0);
    check("rst_wb_ctrl", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 0);
    check("rst_wb_adr_dat", {bus.wb_adr_o, bus.wb_dat_o}, 0);
    check("rst_state", dbg_state, 0);

    // init sequence
    rst_n = 1'b1;
    expect_wr(3'd0, 8'hC7);
    expect_wr(3'd1, 8'h00);
    expect_wr(3'd2, 8'h80);
    wait_ready("init_ready");
    sb_drain("init");

    // write byte, slave ACKs
    expect_wr(3'd3, 8'hA0);
    expect_wr(3'd4, 8'h90);
    expect_wr(3'd3, 8'hA5);
    expect_wr(3'd4, 8'h50);
    send("wr", 1'b0, 7'h50, 8'hA5);
    wait_rsp("wr");
    check("wr_nack", r_nack, 0);
    check("wr_err", r_err, 0);
    check("wr_data", r_data, 8'h00);
    sb_drain("wr");

    // read byte
    rxr_val = 8'h3C;
    expect_wr(3'd3, 8'hA1);
    expect_wr(3'd4, 8'h90);
    expect_wr(3'd4, 8'h68);
    send("rd", 1'b1, 7'h50, 8'hFF);
    wait_rsp("rd");
    check("rd_data", r_data, 8'h3C);
    check("rd_nack", r_nack, 0);
    check("rd_err", r_err, 0);
    sb_drain("rd");
    repeat (3) @(negedge clk);
    check("rd_data_hold", bus.rsp_data, 8'h3C);

    // address NACK
    sr_rxack = 1'b1;
    expect_wr(3'd3, 8'hA0);
    expect_wr(3'd4, 8'h90);
    expect_wr(3'd4, 8'h40);
    send("nack", 1'b0, 7'h50, 8'h11);
    wait_rsp("nack");
    check("nack_flag", r_nack, 1);
    check("nack_err", r_err, 0);
    sb_drain("nack");
    sr_rxack = 1'b0;

    // ack timeout on TX_ADDR
    begin
      bit seen;
      int n;
      ack_block = 1'b1;
      send("tmo", 1'b0, 7'h22, 8'h5A);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (bus.wb_cyc_o) seen = 1'b1;
      end
      check("tmo_cyc_seen", seen, 1);
      n = 1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!bus.wb_cyc_o) break;
        n++;
      end
      check("tmo_cyc_len", n, 16);
      wait_rsp("tmo");
      check("tmo_err", r_err, 1);
      check("tmo_nack", r_nack, 0);
      sb_drain("tmo");
      ack_block = 1'b0;
    end

    // request after timeout accepted without re-init
    expect_wr(3'd3, 8'h22);
    expect_wr(3'd4, 8'h90);
    expect_wr(3'd3, 8'h77);
    expect_wr(3'd4, 8'h50);
    send("post_tmo", 1'b0, 7'h11, 8'h77);
    wait_rsp("post_tmo");
    check("post_tmo_err", r_err, 0);
    check("post_tmo_nack", r_nack, 0);
    sb_drain("post_tmo");

    // reset during WAIT
    begin
      bit hit;
      expect_wr(3'd3, 8'hA1);
      expect_wr(3'd4, 8'h90);
      send("arst", 1'b1, 7'h50, 8'h00);
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
        @(negedge clk);
        if (dbg_state == 4'd6 && bus.wb_cyc_o) hit = 1'b1;
      end
      check("arst_in_wait", hit, 1);
      rst_n = 1'b0;
      #1;
      check("arst_cyc_drop", {bus.wb_cyc_o, bus.wb_stb_o}, 0);
      check("arst_state", dbg_state, 0);
      sb_drain("arst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expect_wr(3'd0, 8'hC7);
      expect_wr(3'd1, 8'h00);
      expect_wr(3'd2, 8'h80);
      wait_ready("reinit_ready");
      sb_drain("reinit");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
